// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences each instruction
// through fetch/decode/execute/memory/write-back and drives all datapath strobes.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNe,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       IllegalOp,
    output logic [3:0] State
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_RWB      = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    // Moore part of the control word; in_fetch gates the MemReady-dependent strobes.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic       in_fetch;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input state_t s, input logic is_bne);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.in_fetch  = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
            end
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMREAD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_RWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.branch_ne     = is_bne;
            end
            S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                c.reg_write = 1'b1;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            S_TRAP: begin
                c.illegal_op = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW:    state_d = S_MEMADR;
                    OP_RTYPE:        state_d = S_EXECUTE;
                    OP_BEQ, OP_BNE:  state_d = S_BRANCH;
                    OP_ADDI:         state_d = S_ADDIEX;
                    OP_J:            state_d = S_JUMP;
                    default:         state_d = S_TRAP;
                endcase
            end
            // IR is stable here, so re-reading the opcode is safe.
            S_MEMADR:   state_d = (Opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (MemReady) state_d = S_FETCH;
            S_EXECUTE:  state_d = S_RWB;
            S_RWB:      state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_ADDIEX:   state_d = S_ADDIWB;
            S_ADDIWB:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_TRAP:     state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
        // Outputs are registered alongside the state, so they decode the next state.
        ctrl_d = decode_ctrl(state_d, Opcode == OP_BNE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= decode_ctrl(S_FETCH, 1'b0);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign IRWrite     = ctrl_q.in_fetch & MemReady;
    assign PCWrite     = ctrl_q.pc_write | (ctrl_q.in_fetch & MemReady);
    assign PCWriteCond = ctrl_q.pc_write_cond;
    assign BranchNe    = ctrl_q.branch_ne;
    assign IorD        = ctrl_q.iord;
    assign MemRead     = ctrl_q.mem_read;
    assign MemWrite    = ctrl_q.mem_write;
    assign MemtoReg    = ctrl_q.mem_to_reg;
    assign RegDst      = ctrl_q.reg_dst;
    assign RegWrite    = ctrl_q.reg_write;
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign ALUOp       = ctrl_q.alu_op;
    assign PCSource    = ctrl_q.pc_source;
    assign IllegalOp   = ctrl_q.illegal_op;
    assign State       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: table-driven instruction sequences
// plus hand-written stall and reset cases, checked cycle by cycle via a scoreboard.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;

    multicycle_control dut (
        .clk(clk), .reset(reset), .Opcode(op), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .IllegalOp(IllegalOp), .State(State)
    );

    always #5 clk = ~clk;

    logic [17:0] act_ctrl;
    assign act_ctrl = {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
                       MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp};

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  st;
        logic [17:0] ctrl;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [5:0]  opc;
        int          n;
        logic [23:0] seq;
        string       name;
    } vec_t;
    vec_t vecs[8];

    // Expected control word per state, straight from the state/output table.
    function automatic logic [17:0] model(input logic [3:0] st, input logic rdy, input logic bne);
        logic pcw, pcwc, bn, iord, mr, mw, irw, m2r, rd, rw, sa, ill;
        logic [1:0] srcb, aop, psrc;
        {pcw, pcwc, bn, iord, mr, mw, irw, m2r, rd, rw, sa, ill} = '0;
        srcb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            4'd0:  begin mr = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            4'd1:  srcb = 2'b11;
            4'd2:  begin sa = 1; srcb = 2'b10; end
            4'd3:  begin mr = 1; iord = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mw = 1; iord = 1; end
            4'd6:  begin sa = 1; aop = 2'b10; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin sa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; bn = bne; end
            4'd9:  begin sa = 1; srcb = 2'b10; end
            4'd10: rw = 1;
            4'd11: begin pcw = 1; psrc = 2'b10; end
            4'd12: ill = 1;
            default: ;
        endcase
        return {pcw, pcwc, bn, iord, mr, mw, irw, m2r, rd, rw, sa, srcb, aop, psrc, ill};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock cycle: called at posedge+1, drives MemReady, checks at negedge.
    task automatic cyc(input logic rdy, input logic [3:0] st, input string tag);
        exp_t e;
        MemReady = rdy;
        sb.push_back('{st: st, ctrl: model(st, rdy, op == 6'b000101)});
        @(negedge clk);
        e = sb.pop_front();
        chk($sformatf("%s state", tag), {28'd0, State}, {28'd0, e.st});
        chk($sformatf("%s ctrl s%0d", tag, e.st), {14'd0, act_ctrl}, {14'd0, e.ctrl});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{opc: 6'b100011, n: 5, seq: 24'h012340, name: "lw"};
        vecs[1] = '{opc: 6'b000000, n: 4, seq: 24'h016700, name: "rtype"};
        vecs[2] = '{opc: 6'b001000, n: 4, seq: 24'h019a00, name: "addi"};
        vecs[3] = '{opc: 6'b000100, n: 3, seq: 24'h018000, name: "beq"};
        vecs[4] = '{opc: 6'b000101, n: 3, seq: 24'h018000, name: "bne"};
        vecs[5] = '{opc: 6'b000010, n: 3, seq: 24'h01b000, name: "j"};
        vecs[6] = '{opc: 6'b111111, n: 3, seq: 24'h01c000, name: "illegal"};
        vecs[7] = '{opc: 6'b101011, n: 4, seq: 24'h012500, name: "sw"};

        reset = 1'b1; MemReady = 1'b0; op = 6'b000000;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset state", {28'd0, State}, 32'd0);
        chk("reset ctrl rdy0", {14'd0, act_ctrl}, {14'd0, model(4'd0, 1'b0, 1'b0)});
        MemReady = 1'b1; #1;
        chk("reset ctrl rdy1", {14'd0, act_ctrl}, {14'd0, model(4'd0, 1'b1, 1'b0)});
        @(posedge clk); #1;
        chk("reset held state", {28'd0, State}, 32'd0);
        reset = 1'b0;

        for (int v = 0; v < 8; v++) begin
            op = vecs[v].opc;
            for (int i = 0; i < vecs[v].n; i++)
                cyc(1'b1, vecs[v].seq[23 - 4*i -: 4], vecs[v].name);
            $display("instr %s op=%b cycles=%0d checks=%0d errors=%0d",
                     vecs[v].name, vecs[v].opc, vecs[v].n, checks, errors);
        end

        op = 6'b000010;
        cyc(1'b0, 4'd0, "fetch_stall"); cyc(1'b0, 4'd0, "fetch_stall");
        cyc(1'b1, 4'd0, "fetch_stall"); cyc(1'b1, 4'd1, "fetch_stall");
        cyc(1'b1, 4'd11, "fetch_stall");
        $display("instr j with 2 fetch waits checks=%0d errors=%0d", checks, errors);

        op = 6'b101011;
        cyc(1'b1, 4'd0, "sw_stall"); cyc(1'b1, 4'd1, "sw_stall"); cyc(1'b1, 4'd2, "sw_stall");
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'd5, "sw_stall");
        cyc(1'b1, 4'd5, "sw_stall");
        $display("instr sw with 3 memwrite waits checks=%0d errors=%0d", checks, errors);

        op = 6'b100011;
        cyc(1'b1, 4'd0, "lw_stall"); cyc(1'b1, 4'd1, "lw_stall"); cyc(1'b1, 4'd2, "lw_stall");
        cyc(1'b0, 4'd3, "lw_stall"); cyc(1'b0, 4'd3, "lw_stall");
        cyc(1'b1, 4'd3, "lw_stall"); cyc(1'b1, 4'd4, "lw_stall");
        $display("instr lw with 2 memread waits checks=%0d errors=%0d", checks, errors);

        op = 6'b101011;
        cyc(1'b1, 4'd0, "rst_mid"); cyc(1'b1, 4'd1, "rst_mid"); cyc(1'b1, 4'd2, "rst_mid");
        MemReady = 1'b0; #1;
        chk("rst_mid memwrite before", {28'd0, State, MemWrite}, {28'd0, 4'd5, 1'b1});
        reset = 1'b1; #1;
        chk("rst_mid async state", {28'd0, State}, 32'd0);
        chk("rst_mid memwrite drop", {31'd0, MemWrite}, 32'd0);
        @(posedge clk); #1;
        chk("rst_mid held", {28'd0, State}, 32'd0);
        reset = 1'b0;
        op = 6'b000010;
        cyc(1'b1, 4'd0, "rst_mid_after"); cyc(1'b1, 4'd1, "rst_mid_after");
        cyc(1'b1, 4'd11, "rst_mid_after");
        $display("reset mid-memwrite then j checks=%0d errors=%0d", checks, errors);

        chk("scoreboard drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
